// File: rtl/cr_sensor_conditioner.sv
// Side-road vehicle detector conditioner: synchroniser, symmetric debounce and request latch.
// Optional arrival statistics counter enabled by defining CR_SENSOR_STATS_EN.
module cr_sensor_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_raw,
    input  logic             cr_served,
    output logic             sensor,
    output logic             db_level,
    output logic             car_arrive,
    output logic [CNT_W-1:0] car_count
);

    localparam int unsigned DBC_W = $clog2(DB_CYCLES + 1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DBC_W-1:0]       dbc_q, dbc_d;
    logic                   db_level_q, db_level_d;
    logic                   req_q, req_d;
    logic                   car_arrive_q, car_arrive_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sensor_raw};
    end

    // Debounce: a new level must be seen DB_CYCLES consecutive cycles; any return restarts.
    always_comb begin
        dbc_d      = dbc_q;
        db_level_d = db_level_q;
        if (sync_bit == db_level_q) begin
            dbc_d = '0;
        end else if (dbc_q == DBC_LAST) begin
            db_level_d = sync_bit;
            dbc_d      = '0;
        end else begin
            dbc_d = dbc_q + DBC_W'(1);
        end
        // Set wins over clear so a fresh arrival is never lost while being served.
        req_d        = db_level_d | (req_q & ~cr_served);
        car_arrive_d = db_level_d & ~db_level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            dbc_q        <= '0;
            db_level_q   <= 1'b0;
            req_q        <= 1'b0;
            car_arrive_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            dbc_q        <= dbc_d;
            db_level_q   <= db_level_d;
            req_q        <= req_d;
            car_arrive_q <= car_arrive_d;
        end
    end

    assign sensor     = req_q;
    assign db_level   = db_level_q;
    assign car_arrive = car_arrive_q;

`ifdef CR_SENSOR_STATS_EN
    logic [CNT_W-1:0] car_count_q, car_count_d;

    // Saturating arrival counter, cleared only by reset.
    always_comb begin
        car_count_d = car_count_q;
        if (car_arrive_q && (car_count_q != {CNT_W{1'b1}})) begin
            car_count_d = car_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            car_count_q <= '0;
        end else begin
            car_count_q <= car_count_d;
        end
    end

    assign car_count = car_count_q;
`else
    assign car_count = '0;
`endif

endmodule

// File: tb/tb_cr_sensor_conditioner.sv
// Directed self-checking bench for cr_sensor_conditioner with default parameters.
module tb_cr_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_raw;
    logic       cr_served;
    logic       sensor;
    logic       db_level;
    logic       car_arrive;
    logic [7:0] car_count;

    int errors = 0;
    int checks = 0;
    int arrive_cnt = 0;

    cr_sensor_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .cr_served  (cr_served),
        .sensor     (sensor),
        .db_level   (db_level),
        .car_arrive (car_arrive),
        .car_count  (car_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (car_arrive === 1'b1) arrive_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; sensor_raw = 1'b0; cr_served = 1'b0;
        step();
        rst = 1'b0;
        arrive_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sensor_raw = 1'b1; cr_served = 1'b0;
        steps(3);
        checks++;
        if ({sensor, db_level, car_arrive} !== 3'b000) begin
            errors++; $display("FAIL reset_outs: got %b%b%b want 000", sensor, db_level, car_arrive);
        end
        checks++;
        if (car_count !== 8'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", car_count);
        end
        rst = 1'b0;
        arrive_cnt = 0;
        steps(9);
        checks++;
        if (sensor !== 1'b0) begin
            errors++; $display("FAIL reset_edge9: sensor got %b want 0", sensor);
        end
        step();
        checks++;
        if ({sensor, db_level, car_arrive} !== 3'b111) begin
            errors++; $display("FAIL reset_edge10: got %b%b%b want 111", sensor, db_level, car_arrive);
        end
        step();
        checks++;
        if (car_arrive !== 1'b0) begin
            errors++; $display("FAIL reset_pulse_width: car_arrive got %b want 0", car_arrive);
        end
    endtask

    task automatic test_glitch_reject();
        logic seen;
        do_reset();
        seen = 1'b0;
        sensor_raw = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(); seen = seen | sensor | db_level | car_arrive;
        end
        sensor_raw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(); seen = seen | sensor | db_level | car_arrive;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL glitch_7cyc: some output went 1, want all 0");
        end
        // Long high with a single-cycle dip: one arrival only.
        sensor_raw = 1'b1; steps(20);
        sensor_raw = 1'b0; step();
        sensor_raw = 1'b1; steps(20);
        checks++;
        if (arrive_cnt !== 1) begin
            errors++; $display("FAIL dip_arrivals: got %0d want 1", arrive_cnt);
        end
        checks++;
        if (db_level !== 1'b1) begin
            errors++; $display("FAIL dip_level: db_level got %b want 1", db_level);
        end
    endtask

    task automatic test_latch();
        do_reset();
        sensor_raw = 1'b1; steps(20);
        sensor_raw = 1'b0;
        steps(9);
        checks++;
        if (db_level !== 1'b1) begin
            errors++; $display("FAIL latch_fall9: db_level got %b want 1", db_level);
        end
        step();
        checks++;
        if ({db_level, sensor} !== 2'b01) begin
            errors++; $display("FAIL latch_fall10: db_level,sensor got %b%b want 01", db_level, sensor);
        end
        steps(5);
        checks++;
        if (sensor !== 1'b1) begin
            errors++; $display("FAIL latch_hold: sensor got %b want 1", sensor);
        end
        cr_served = 1'b1; step(); cr_served = 1'b0;
        checks++;
        if (sensor !== 1'b0) begin
            errors++; $display("FAIL latch_clear: sensor got %b want 0", sensor);
        end
        checks++;
        if (arrive_cnt !== 1) begin
            errors++; $display("FAIL latch_arrivals: got %0d want 1", arrive_cnt);
        end
    endtask

    task automatic test_served_follow();
        do_reset();
        cr_served = 1'b1; sensor_raw = 1'b1;
        steps(9);
        checks++;
        if (sensor !== 1'b0) begin
            errors++; $display("FAIL follow_rise9: sensor got %b want 0", sensor);
        end
        step();
        checks++;
        if (sensor !== 1'b1) begin
            errors++; $display("FAIL follow_rise10: sensor got %b want 1 (set wins)", sensor);
        end
        steps(20);
        sensor_raw = 1'b0;
        steps(9);
        checks++;
        if (sensor !== 1'b1) begin
            errors++; $display("FAIL follow_fall9: sensor got %b want 1", sensor);
        end
        step();
        checks++;
        if ({sensor, db_level} !== 2'b00) begin
            errors++; $display("FAIL follow_fall10: sensor,db_level got %b%b want 00", sensor, db_level);
        end
        cr_served = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        sensor_raw = 1'b1;
        steps(4);
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({sensor, db_level} !== 2'b00) begin
            errors++; $display("FAIL midrst_clear: got %b%b want 00", sensor, db_level);
        end
        steps(9);
        checks++;
        if (sensor !== 1'b0) begin
            errors++; $display("FAIL midrst_edge9: sensor got %b want 0", sensor);
        end
        step();
        checks++;
        if (sensor !== 1'b1) begin
            errors++; $display("FAIL midrst_edge10: sensor got %b want 1", sensor);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp3, exp_sat;
`ifdef CR_SENSOR_STATS_EN
        exp3 = 8'd3; exp_sat = 8'd255;
`else
        exp3 = 8'd0; exp_sat = 8'd0;
`endif
        do_reset();
        cr_served = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sensor_raw = 1'b1; steps(12);
            sensor_raw = 1'b0; steps(12);
        end
        checks++;
        if (car_count !== exp3) begin
            errors++; $display("FAIL count3: got %0d want %0d", car_count, exp3);
        end
        for (int c = 3; c < 300; c++) begin
            sensor_raw = 1'b1; steps(12);
            sensor_raw = 1'b0; steps(12);
        end
        checks++;
        if (arrive_cnt !== 300) begin
            errors++; $display("FAIL arrivals300: got %0d want 300", arrive_cnt);
        end
        checks++;
        if (car_count !== exp_sat) begin
            errors++; $display("FAIL count_sat: got %0d want %0d", car_count, exp_sat);
        end
        cr_served = 1'b0;
        do_reset();
        checks++;
        if (car_count !== 8'd0) begin
            errors++; $display("FAIL count_rst: got %0d want 0", car_count);
        end
    endtask

    initial begin
        rst = 1'b1; sensor_raw = 1'b0; cr_served = 1'b0;
        test_reset();
        test_glitch_reject();
        test_latch();
        test_served_follow();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
